dsp_cic_dec_mc: RTL and testbench
=================================

Name: dsp_cic_dec_mc

Overview:
- Multi-channel, time-interleaved CIC decimator with sample-valid qualification, runtime decimation factor and runtime output gain shift.
- Output is rounded (or truncated) and saturated.
- Sits after the channeliser / NCO mixer; one instance serves CH channels arriving round-robin on one bus.
- Per-channel integrator and comb state is held in register arrays.
- Supports R=1 (dec_fac=0) and glitch-free dec_fac changes at decimation-period boundaries.

Parameters:
- CH, 4, channel count (1..16); samples arrive ch0..CH-1 repeating.
- M, 1, differential delay (1 or 2).
- N, 3, stages per side.
- BIN, 16, input width, two's complement.
- DFW, 9, dec_fac width; R = dec_fac+1, 1..2^DFW.
- BOUT, 43, full-precision width = BIN + N*ceil(log2(2^DFW*M)).
- COUT, 16, dout_cut width.
- SHW, 6, gain_sh width (>= clog2(BOUT)).
- CUT_METHOD, "ROUND", "ROUND" (round half up) or "CUT" (floor).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all state, counters and outputs.
- dec_fac  in  DFW  decimation factor minus 1; sampled at period start.
- gain_sh  in  SHW  arithmetic right shift applied before dout_cut; valid range 0..BOUT-1.
- din  in  BIN  input sample of channel ch_cnt.
- din_vld  in  1  din valid; no backpressure.
- dout  out  BOUT  full-precision comb output.
- dout_cut  out  COUT  shifted, rounded, saturated output.
- dout_ch  out  clog2(CH) (min 1)  channel of dout.
- dout_vld  out  1  output strobe.

Behaviour:
- Reset (rst_n=0, async) and clr=1 (sync, dominates din_vld):
  - All integrators, combs (including the M=2 second delay), ch_cnt, ph_cnt, dec_act, dout, dout_cut, dout_ch and dout_vld clear to 0.
  - A sample presented with clr=1 is discarded.
- Channel counter ch_cnt:
  - Increments on each accepted sample (din_vld=1); wraps CH-1 -> 0.
  - Cycles with din_vld=0 change no state and hold dout and dout_ch.
- Phase counter ph_cnt:
  - Counts frames (CH samples) in the current period.
  - Period start is defined as din_vld=1 with ch_cnt=0 and ph_cnt=0. At period start, dec_act <= dec_fac, and this same-cycle dec_fac value (dec_eff) governs the period.
  - Outside period start, dec_eff = dec_act; dec_fac changes mid-period do not take effect until the next period start.
  - ph_cnt increments when the sample with ch_cnt=CH-1 is accepted; it returns to 0 when it equals dec_eff.
- Integrators, per accepted sample of channel c:
  - Stage 0 adds sign-extended din to I[c][0].
  - Stage k adds the new stage k-1 sum to I[c][k]; the chain is combinational in one cycle.
  - All stages update at the clock edge.
  - Arithmetic is modulo 2^BOUT; wrap is intended and is cancelled by the combs.
- Decimation:
  - A sample is decimating when ph_cnt = dec_eff.
  - For a decimating sample, the new last-stage sum passes through the N comb stages of channel c combinationally.
  - Each comb j computes x - D[c][j] (M=1) or x - D2[c][j] (M=2).
  - Comb delays update only on decimating samples of that channel.
- Output timing:
  - dout, dout_ch and dout_cut are registered on the decimating sample's edge.
  - dout_vld = 1 for exactly the following cycle; latency is 1 clock.
  - With dec_fac=0, every sample is decimating; back-to-back samples give continuous dout_vld.
- dout_cut:
  - t = dout sign-extended to BOUT+1 bits.
  - In ROUND mode with gain_sh>0, add 2^(gain_sh-1) to t.
  - Then arithmetic right shift t by gain_sh.
  - Saturate to [-2^(COUT-1), 2^(COUT-1)-1].
  - gain_sh is sampled at the same edge as dout.
- DC gain is (R*M)^N. Overflow of dout beyond BOUT is the user's responsibility; BOUT must be sized for the maximum R.

Test Plan:
- CH=1, N=3, M=1, dec_fac=3, din=+1 continuous, gain_sh=0 -> dout_vld once every 4 clocks, latency 1. From the 3rd output onward, dout=64 and dout_cut=64.
- CH=4, dec_fac=3, constant inputs ch0..3 = 1, 2, -1, 0, din_vld=1 -> settled outputs 64, 128, -64, 0 on four consecutive dout_vld cycles with dout_ch=0, 1, 2, 3.
- Same as the CH=4 test with random din_vld gaps (about 40% idle) -> dout sequence per channel bit-identical to the gapless run; dout_vld never asserted without a decimating sample the cycle before.
- CH=1, dec_fac changes 3->1 one clock after a period start, din=+1 -> current period still R=4 (dout_vld spacing 4). From the next period onward, spacing is 2, and the 3rd output after the change onward gives dout=8.
- N=1, M=1, CH=1, dec_fac=0, ROUND:
  - din=5, gain_sh=1 -> dout=5, dout_cut=3.
  - din=-5 -> dout_cut=-2.
  - Same inputs in CUT mode -> 2 and -3.
- N=3, dec_fac=3, din=-32768 -> settled dout=-2097152.
  - gain_sh=0 -> dout_cut=-32768 (saturated).
  - gain_sh=7 ROUND -> -16384.
  - din=32767, gain_sh=0 -> 32767 (saturated).
- Assert clr (or rst_n=0) mid-period, then release -> all outputs 0; the first output appears after exactly dec_fac+1 frames with values matching a fresh start.

Source files
------------

// File: rtl/dsp_cic_dec_mc.sv
// Multi-channel time-interleaved CIC decimator: per-channel integrator/comb state,
// runtime decimation factor and output gain shift with round/cut and saturation.
module dsp_cic_dec_mc #(
    parameter int    CH         = 4,
    parameter int    M          = 1,
    parameter int    N          = 3,
    parameter int    BIN        = 16,
    parameter int    DFW        = 9,
    parameter int    BOUT       = 43,
    parameter int    COUT       = 16,
    parameter int    SHW        = 6,
    parameter string CUT_METHOD = "ROUND",
    localparam int   CHW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [DFW-1:0]  dec_fac,
    input  logic [SHW-1:0]  gain_sh,
    input  logic [BIN-1:0]  din,
    input  logic            din_vld,
    output logic [BOUT-1:0] dout,
    output logic [COUT-1:0] dout_cut,
    output logic [CHW-1:0]  dout_ch,
    output logic            dout_vld
);

    localparam bit ROUND_EN = (CUT_METHOD == "ROUND");

    logic [BOUT-1:0] integ_q [CH][N];
    logic [BOUT-1:0] dly1_q  [CH][N];
    logic [BOUT-1:0] dly2_q  [CH][N];

    logic [CHW-1:0]  ch_cnt_q, ch_cnt_d;
    logic [DFW-1:0]  ph_cnt_q, ph_cnt_d;
    logic [DFW-1:0]  dec_act_q, dec_act_d;
    logic [DFW-1:0]  dec_eff;
    logic [BOUT-1:0] dout_q, dout_d;
    logic [COUT-1:0] cut_q, cut_d;
    logic [CHW-1:0]  dout_ch_q;
    logic            vld_q;

    logic            period_start, dec_smp, frame_end;
    logic [BOUT-1:0] isel  [N];
    logic [BOUT-1:0] dsel1 [N];
    logic [BOUT-1:0] dsel2 [N];
    logic [BOUT-1:0] isum  [N];
    logic [BOUT-1:0] cin   [N];
    logic [BOUT-1:0] cdiff [N];
    logic signed [BOUT:0] rnd_t, sh_t;
    logic [BOUT-COUT+1:0] sh_hi;

    // Current channel's state is muxed out once and shared by the whole datapath.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            isel[k]  = '0;
            dsel1[k] = '0;
            dsel2[k] = '0;
        end
        for (int unsigned c = 0; c < CH; c++) begin
            if (CHW'(c) == ch_cnt_q) begin
                for (int unsigned k = 0; k < N; k++) begin
                    isel[k]  = integ_q[c][k];
                    dsel1[k] = dly1_q[c][k];
                    dsel2[k] = dly2_q[c][k];
                end
            end
        end
    end

    always_comb begin
        period_start = din_vld && (ch_cnt_q == '0) && (ph_cnt_q == '0);
        dec_eff      = period_start ? dec_fac : dec_act_q;
        dec_smp      = din_vld && (ph_cnt_q == dec_eff);
        frame_end    = (ch_cnt_q == CHW'(CH - 1));
        dec_act_d    = period_start ? dec_fac : dec_act_q;

        ch_cnt_d = ch_cnt_q;
        ph_cnt_d = ph_cnt_q;
        if (din_vld) begin
            ch_cnt_d = frame_end ? '0 : ch_cnt_q + 1'b1;
            if (frame_end) begin
                ph_cnt_d = (ph_cnt_q == dec_eff) ? '0 : ph_cnt_q + 1'b1;
            end
        end

        isum[0] = isel[0] + {{(BOUT-BIN){din[BIN-1]}}, din};
        for (int unsigned k = 1; k < N; k++) begin
            isum[k] = isel[k] + isum[k-1];
        end

        cin[0] = isum[N-1];
        for (int unsigned j = 0; j < N; j++) begin
            cdiff[j] = cin[j] - ((M == 2) ? dsel2[j] : dsel1[j]);
            if (j < N - 1) begin
                cin[j+1] = cdiff[j];
            end
        end
        dout_d = cdiff[N-1];

        // One guard bit keeps the rounding add from overflowing before the shift.
        rnd_t = {dout_d[BOUT-1], dout_d};
        if (ROUND_EN && (gain_sh != '0)) begin
            rnd_t = rnd_t + ((BOUT+1)'(1) << (gain_sh - 1'b1));
        end
        sh_t  = rnd_t >>> gain_sh;
        sh_hi = sh_t[BOUT:COUT-1];
        if ((&sh_hi) || (~|sh_hi)) begin
            cut_d = sh_t[COUT-1:0];
        end else if (sh_t[BOUT]) begin
            cut_d = {1'b1, {(COUT-1){1'b0}}};
        end else begin
            cut_d = {1'b0, {(COUT-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    integ_q[c][k] <= '0;
                    dly1_q[c][k]  <= '0;
                    dly2_q[c][k]  <= '0;
                end
            end
            ch_cnt_q  <= '0;
            ph_cnt_q  <= '0;
            dec_act_q <= '0;
            dout_q    <= '0;
            cut_q     <= '0;
            dout_ch_q <= '0;
            vld_q     <= 1'b0;
        end else if (clr) begin
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    integ_q[c][k] <= '0;
                    dly1_q[c][k]  <= '0;
                    dly2_q[c][k]  <= '0;
                end
            end
            ch_cnt_q  <= '0;
            ph_cnt_q  <= '0;
            dec_act_q <= '0;
            dout_q    <= '0;
            cut_q     <= '0;
            dout_ch_q <= '0;
            vld_q     <= 1'b0;
        end else begin
            vld_q <= dec_smp;
            if (din_vld) begin
                ch_cnt_q  <= ch_cnt_d;
                ph_cnt_q  <= ph_cnt_d;
                dec_act_q <= dec_act_d;
                for (int unsigned c = 0; c < CH; c++) begin
                    if (CHW'(c) == ch_cnt_q) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            integ_q[c][k] <= isum[k];
                            if (dec_smp) begin
                                dly1_q[c][k] <= cin[k];
                                dly2_q[c][k] <= dly1_q[c][k];
                            end
                        end
                    end
                end
            end
            if (dec_smp) begin
                dout_q    <= dout_d;
                cut_q     <= cut_d;
                dout_ch_q <= ch_cnt_q;
            end
        end
    end

    assign dout     = dout_q;
    assign dout_cut = cut_q;
    assign dout_ch  = dout_ch_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_dsp_cic_dec_mc.sv
// Bench for dsp_cic_dec_mc: four instances checked against a convolution
// (boxcar^N impulse response) reference model and fixed expected constants.
module tb_dsp_cic_dec_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // a: CH=1 N=3, b: CH=4 N=3, c: CH=1 N=1 ROUND, d: CH=1 N=1 CUT
    logic        a_clr = 0, b_clr = 0, c_clr = 0, d_clr = 0;
    logic [8:0]  a_dec = 0, b_dec = 0, c_dec = 0, d_dec = 0;
    logic [5:0]  a_sh = 0, b_sh = 0, c_sh = 0, d_sh = 0;
    logic [15:0] a_din = 0, b_din = 0, c_din = 0, d_din = 0;
    logic        a_vld = 0, b_vld = 0, c_vld = 0, d_vld = 0;
    logic [42:0] a_dout, b_dout, c_dout, d_dout;
    logic [15:0] a_cut, b_cut, c_cut, d_cut;
    logic [0:0]  a_ch, c_ch, d_ch;
    logic [1:0]  b_ch;
    logic        a_ov, b_ov, c_ov, d_ov;

    dsp_cic_dec_mc #(.CH(1), .N(3), .M(1), .CUT_METHOD("ROUND")) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .dec_fac(a_dec), .gain_sh(a_sh),
        .din(a_din), .din_vld(a_vld), .dout(a_dout), .dout_cut(a_cut),
        .dout_ch(a_ch), .dout_vld(a_ov));
    dsp_cic_dec_mc #(.CH(4), .N(3), .M(1), .CUT_METHOD("ROUND")) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .dec_fac(b_dec), .gain_sh(b_sh),
        .din(b_din), .din_vld(b_vld), .dout(b_dout), .dout_cut(b_cut),
        .dout_ch(b_ch), .dout_vld(b_ov));
    dsp_cic_dec_mc #(.CH(1), .N(1), .M(1), .CUT_METHOD("ROUND")) u_c (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .dec_fac(c_dec), .gain_sh(c_sh),
        .din(c_din), .din_vld(c_vld), .dout(c_dout), .dout_cut(c_cut),
        .dout_ch(c_ch), .dout_vld(c_ov));
    dsp_cic_dec_mc #(.CH(1), .N(1), .M(1), .CUT_METHOD("CUT")) u_d (
        .clk(clk), .rst_n(rst_n), .clr(d_clr), .dec_fac(d_dec), .gain_sh(d_sh),
        .din(d_din), .din_vld(d_vld), .dout(d_dout), .dout_cut(d_cut),
        .dout_ch(d_ch), .dout_vld(d_ov));

    // Reference model state for a (index 0) and b (index 1)
    int     nch [2] = '{1, 4};
    int     rr  [2];
    int     hh  [2][0:127];
    int     hl  [2];
    int     mch [2];
    int     cnt [2][4];
    longint hist[2][4][0:2047];

    function automatic logic [15:0] cut_ref(input longint v, input int sh, input bit rnd);
        longint t;
        t = v;
        if (rnd && sh > 0) t = t + (longint'(1) <<< (sh - 1));
        t = t >>> sh;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t[15:0];
    endfunction

    // Impulse response of N=3 cascaded length-R moving sums.
    task automatic set_dec(input int d, input int r);
        int tmp[0:127];
        int nl, s;
        if (d == 0) a_dec = 9'(r - 1); else b_dec = 9'(r - 1);
        rr[d] = r;
        for (int i = 0; i < 128; i++) hh[d][i] = 0;
        hh[d][0] = 1;
        hl[d] = 1;
        repeat (3) begin
            nl = hl[d] + r - 1;
            for (int i = 0; i < nl; i++) begin
                s = 0;
                for (int j = 0; j < r; j++)
                    if (i - j >= 0 && i - j < hl[d]) s += hh[d][i-j];
                tmp[i] = s;
            end
            for (int i = 0; i < nl; i++) hh[d][i] = tmp[i];
            hl[d] = nl;
        end
    endtask

    task automatic model_clear(input int d);
        mch[d] = 0;
        for (int c = 0; c < 4; c++) cnt[d][c] = 0;
    endtask

    task automatic do_clr(input int d);
        if (d == 0) begin a_clr = 1; a_vld = 1; a_din = 16'($urandom); end
        else        begin b_clr = 1; b_vld = 1; b_din = 16'($urandom); end
        @(posedge clk); #1;
        a_clr = 0; b_clr = 0; a_vld = 0; b_vld = 0;
        model_clear(d);
    endtask

    // Drives one cycle on DUT d and returns model expectations and DUT observations.
    task automatic step(input int d, input bit v, input logic signed [15:0] x,
                        output bit ev, output logic [42:0] ed, output int ec,
                        output logic [15:0] ecut, output logic ov,
                        output logic [42:0] od, output int oc, output logic [15:0] ocut);
        int c, n, sh;
        longint acc;
        ev = 0; ed = '0; ec = 0; ecut = '0;
        sh = (d == 0) ? int'(a_sh) : int'(b_sh);
        if (d == 0) begin a_vld = v; a_din = x; end
        else        begin b_vld = v; b_din = x; end
        if (v) begin
            c = mch[d];
            n = cnt[d][c];
            hist[d][c][n] = x;
            cnt[d][c] = n + 1;
            if ((n + 1) % rr[d] == 0) begin
                acc = 0;
                for (int k = 0; k < hl[d]; k++)
                    if (n - k >= 0) acc += longint'(hh[d][k]) * hist[d][c][n-k];
                ev = 1;
                ed = acc[42:0];
                ec = c;
                ecut = cut_ref(acc, sh, 1'b1);
            end
            mch[d] = (c + 1) % nch[d];
        end
        @(posedge clk); #1;
        if (d == 0) begin ov = a_ov; od = a_dout; oc = int'(a_ch); ocut = a_cut; end
        else        begin ov = b_ov; od = b_dout; oc = int'(b_ch); ocut = b_cut; end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_dout, a_cut, a_ov, b_dout, b_cut, b_ch, b_ov, c_dout, c_cut, c_ov, d_dout, d_cut, d_ov} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got a=%0h b=%0h c=%0h d=%0h required all 0", a_dout, b_dout, c_dout, d_dout);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({a_ov, b_ov, c_ov, d_ov, b_dout, b_ch} !== '0) begin
            errors++;
            $display("FAIL reset_idle got vld=%b%b%b%b dout=%0h required 0", a_ov, b_ov, c_ov, d_ov, b_dout);
        end
    endtask

    task automatic test_dc_ch1();
        bit ev; logic [42:0] ed, od; int ec, oc, nout; logic [15:0] ecut, ocut; logic ov;
        do_clr(0);
        set_dec(0, 4);
        a_sh = 0;
        nout = 0;
        for (int s = 0; s < 24; s++) begin
            step(0, 1'b1, 16'sd1, ev, ed, ec, ecut, ov, od, oc, ocut);
            checks++;
            if (ov !== ev) begin errors++; $display("FAIL dc_vld s=%0d got %b required %b", s, ov, ev); end
            if (ev) begin
                nout++;
                checks++;
                if (od !== ed || ocut !== ecut || oc !== ec) begin
                    errors++;
                    $display("FAIL dc_out s=%0d got %0d/%0d required %0d/%0d", s, $signed(od), $signed(ocut), $signed(ed), $signed(ecut));
                end
                if (nout >= 3) begin
                    checks++;
                    if (od !== 43'd64 || ocut !== 16'd64) begin
                        errors++;
                        $display("FAIL dc_settled s=%0d got %0d/%0d required 64/64", s, $signed(od), $signed(ocut));
                    end
                end
            end
        end
        a_vld = 0;
    endtask

    task automatic test_multi_ch();
        bit ev; logic [42:0] ed, od; int ec, oc; logic [15:0] ecut, ocut; logic ov;
        logic signed [15:0] vals[4] = '{16'sd1, 16'sd2, -16'sd1, 16'sd0};
        logic signed [42:0] settled[4] = '{43'sd64, 43'sd128, -43'sd64, 43'sd0};
        int prev_ch;
        do_clr(1);
        set_dec(1, 4);
        b_sh = 0;
        prev_ch = 3;
        for (int s = 0; s < 64; s++) begin
            step(1, 1'b1, vals[mch[1]], ev, ed, ec, ecut, ov, od, oc, ocut);
            checks++;
            if (ov !== ev) begin errors++; $display("FAIL mc_vld s=%0d got %b required %b", s, ov, ev); end
            if (ev) begin
                checks++;
                if (od !== ed || ocut !== ecut || oc !== ec) begin
                    errors++;
                    $display("FAIL mc_out s=%0d ch %0d got %0d required %0d", s, oc, $signed(od), $signed(ed));
                end
                if (s >= 44) begin
                    checks++;
                    if (od !== settled[oc] || oc !== (prev_ch + 1) % 4) begin
                        errors++;
                        $display("FAIL mc_settled s=%0d ch %0d got %0d required %0d", s, oc, $signed(od), settled[(prev_ch + 1) % 4]);
                    end
                end
                prev_ch = oc;
            end
        end
        b_vld = 0;
    endtask

    task automatic test_gaps();
        bit ev, v; logic [42:0] ed, od; int ec, oc; logic [15:0] ecut, ocut; logic ov;
        logic signed [15:0] vals[4] = '{16'sd1, 16'sd2, -16'sd1, 16'sd0};
        do_clr(1);
        set_dec(1, 4);
        b_sh = 0;
        for (int s = 0; s < 200; s++) begin
            v = ($urandom_range(0, 99) >= 40);
            step(1, v, vals[mch[1]], ev, ed, ec, ecut, ov, od, oc, ocut);
            checks++;
            if (ov !== ev) begin errors++; $display("FAIL gap_vld s=%0d got %b required %b", s, ov, ev); end
            if (ev) begin
                checks++;
                if (od !== ed || oc !== ec) begin
                    errors++;
                    $display("FAIL gap_out s=%0d ch %0d got %0d required %0d", s, oc, $signed(od), $signed(ed));
                end
            end
        end
        for (int run = 0; run < 3; run++) begin
            do_clr(1);
            set_dec(1, $urandom_range(1, 8));
            b_sh = 6'($urandom_range(0, 12));
            for (int s = 0; s < 300; s++) begin
                v = ($urandom_range(0, 99) >= 40);
                step(1, v, 16'($urandom), ev, ed, ec, ecut, ov, od, oc, ocut);
                checks++;
                if (ov !== ev) begin errors++; $display("FAIL rnd_vld r=%0d s=%0d got %b required %b", rr[1], s, ov, ev); end
                if (ev) begin
                    checks++;
                    if (od !== ed || ocut !== ecut || oc !== ec) begin
                        errors++;
                        $display("FAIL rnd_out r=%0d s=%0d got %0d/%0d/%0d required %0d/%0d/%0d", rr[1], s,
                                 $signed(od), $signed(ocut), oc, $signed(ed), $signed(ecut), ec);
                    end
                end
            end
        end
        b_vld = 0;
    endtask

    task automatic test_clr();
        bit ev, v; logic [42:0] ed, od; int ec, oc; logic [15:0] ecut, ocut; logic ov;
        do_clr(1);
        set_dec(1, 4);
        b_sh = 3;
        for (int s = 0; s < 37; s++) step(1, 1'b1, 16'($urandom), ev, ed, ec, ecut, ov, od, oc, ocut);
        b_clr = 1; b_vld = 1; b_din = 16'h7FFF;
        @(posedge clk); #1;
        b_clr = 0; b_vld = 0;
        model_clear(1);
        checks++;
        if ({b_dout, b_cut, b_ch, b_ov} !== '0) begin
            errors++;
            $display("FAIL clr_outputs got dout=%0h cut=%0h ch=%0d vld=%b required 0", b_dout, b_cut, b_ch, b_ov);
        end
        for (int s = 0; s < 120; s++) begin
            v = ($urandom_range(0, 99) >= 30);
            step(1, v, 16'($urandom), ev, ed, ec, ecut, ov, od, oc, ocut);
            checks++;
            if (ov !== ev) begin errors++; $display("FAIL clr_vld s=%0d got %b required %b", s, ov, ev); end
            if (ev) begin
                checks++;
                if (od !== ed || ocut !== ecut || oc !== ec) begin
                    errors++;
                    $display("FAIL clr_out s=%0d got %0d required %0d", s, $signed(od), $signed(ed));
                end
            end
        end
        b_vld = 0;
    endtask

    task automatic test_dec_change();
        bit ev;
        do_clr(0);
        a_dec = 9'd3;
        a_sh = 0;
        a_vld = 1; a_din = 16'd1;
        for (int s = 0; s < 26; s++) begin
            if (s == 9) a_dec = 9'd1;
            @(posedge clk); #1;
            ev = (s == 3) || (s == 7) || (s >= 11 && (s % 2) == 1);
            checks++;
            if (a_ov !== ev) begin errors++; $display("FAIL dchg_vld s=%0d got %b required %b", s, a_ov, ev); end
            if (s == 11) begin
                checks++;
                if (a_dout !== 43'd64) begin errors++; $display("FAIL dchg_last_r4 got %0d required 64", $signed(a_dout)); end
            end
            if (s >= 17 && ev) begin
                checks++;
                if (a_dout !== 43'd8 || a_cut !== 16'd8) begin
                    errors++;
                    $display("FAIL dchg_r2 s=%0d got %0d/%0d required 8/8", s, $signed(a_dout), $signed(a_cut));
                end
            end
        end
        a_vld = 0;
    endtask

    task automatic test_round_cut();
        logic signed [15:0] xv[4] = '{16'sd5, -16'sd5, 16'sd5, -16'sd5};
        logic [15:0] rc[2] = '{16'd3, 16'hFFFE};
        logic [15:0] tc[2] = '{16'd2, 16'hFFFD};
        logic signed [15:0] x;
        int sh;
        c_vld = 1; d_vld = 1;
        for (int i = 0; i < 2; i++) begin
            c_din = xv[i]; d_din = xv[i]; c_sh = 6'd1; d_sh = 6'd1;
            @(posedge clk); #1;
            checks++;
            if (c_dout !== 43'(xv[i]) || c_cut !== rc[i] || d_cut !== tc[i]) begin
                errors++;
                $display("FAIL rc_fixed din=%0d got dout %0d round %0d cut %0d required %0d %0d %0d",
                         xv[i], $signed(c_dout), $signed(c_cut), $signed(d_cut), xv[i], $signed(rc[i]), $signed(tc[i]));
            end
        end
        for (int i = 0; i < 60; i++) begin
            x = 16'($urandom);
            sh = $urandom_range(0, 42);
            c_din = x; d_din = x; c_sh = 6'(sh); d_sh = 6'(sh);
            @(posedge clk); #1;
            checks++;
            if (c_ov !== 1'b1 || c_dout !== 43'(x) || d_dout !== 43'(x) ||
                c_cut !== cut_ref(longint'(x), sh, 1'b1) || d_cut !== cut_ref(longint'(x), sh, 1'b0)) begin
                errors++;
                $display("FAIL rc_rand din=%0d sh=%0d got vld %b round %0d cut %0d required 1 %0d %0d", x, sh, c_ov,
                         $signed(c_cut), $signed(d_cut), $signed(cut_ref(longint'(x), sh, 1'b1)), $signed(cut_ref(longint'(x), sh, 1'b0)));
            end
        end
        c_vld = 0; d_vld = 0;
    endtask

    task automatic test_saturation();
        bit ev; logic [42:0] ed, od; int ec, oc; logic [15:0] ecut, ocut; logic ov;
        logic [42:0] last_d; logic [15:0] last_c;
        logic signed [42:0] kneg = -43'sd2097152;
        logic signed [42:0] kpos = 43'sd2097088;
        do_clr(0);
        set_dec(0, 4);
        for (int ph = 0; ph < 3; ph++) begin
            a_sh = (ph == 1) ? 6'd7 : 6'd0;
            last_d = '0; last_c = '0;
            for (int s = 0; s < 16; s++) begin
                step(0, 1'b1, (ph == 2) ? 16'sd32767 : -16'sd32768, ev, ed, ec, ecut, ov, od, oc, ocut);
                checks++;
                if (ov !== ev) begin errors++; $display("FAIL sat_vld ph=%0d s=%0d got %b required %b", ph, s, ov, ev); end
                if (ev) begin
                    checks++;
                    if (od !== ed || ocut !== ecut) begin
                        errors++;
                        $display("FAIL sat_out ph=%0d s=%0d got %0d/%0d required %0d/%0d", ph, s, $signed(od), $signed(ocut), $signed(ed), $signed(ecut));
                    end
                    last_d = od; last_c = ocut;
                end
            end
            checks++;
            if ((ph == 0 && (last_d !== kneg || last_c !== 16'h8000)) ||
                (ph == 1 && (last_d !== kneg || last_c !== 16'hC000)) ||
                (ph == 2 && (last_d !== kpos || last_c !== 16'h7FFF))) begin
                errors++;
                $display("FAIL sat_settled ph=%0d got dout %0d cut %0d", ph, $signed(last_d), $signed(last_c));
            end
        end
        a_vld = 0;
    endtask

    task automatic test_async_reset();
        bit ev, v; logic [42:0] ed, od; int ec, oc; logic [15:0] ecut, ocut; logic ov;
        do_clr(1);
        set_dec(1, 3);
        b_sh = 2;
        for (int s = 0; s < 22; s++) step(1, 1'b1, 16'($urandom), ev, ed, ec, ecut, ov, od, oc, ocut);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({a_dout, a_ov, b_dout, b_cut, b_ch, b_ov, c_dout, d_dout} !== '0) begin
            errors++;
            $display("FAIL arst_outputs got b_dout=%0h b_cut=%0h b_vld=%b required 0", b_dout, b_cut, b_ov);
        end
        #4 rst_n = 1;
        b_vld = 0;
        @(posedge clk); #1;
        model_clear(1);
        for (int s = 0; s < 100; s++) begin
            v = ($urandom_range(0, 99) >= 25);
            step(1, v, 16'($urandom), ev, ed, ec, ecut, ov, od, oc, ocut);
            checks++;
            if (ov !== ev) begin errors++; $display("FAIL arst_vld s=%0d got %b required %b", s, ov, ev); end
            if (ev) begin
                checks++;
                if (od !== ed || ocut !== ecut || oc !== ec) begin
                    errors++;
                    $display("FAIL arst_out s=%0d got %0d required %0d", s, $signed(od), $signed(ed));
                end
            end
        end
        b_vld = 0;
    endtask

    initial begin
        test_reset();
        test_dc_ch1();
        test_multi_ch();
        test_gaps();
        test_clr();
        test_dec_change();
        test_round_cut();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
